// File: rtl/uart_receiver.sv
// 8N1 UART receive path: 2-flop synchronizer, mid-bit sampling frame FSM and
// a show-ahead byte FIFO with valid/ready delivery plus framing/overrun pulses.
module uart_receiver #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_error,
    output logic       overrun_error
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_TC = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL_TC = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            sync1_q, rx_s_q;
    logic            frame_err_q, overrun_q;
    logic            tick, stop_ok, stop_bad;

    logic [AW:0]                 wptr_q, rptr_q;
    logic [FIFO_DEPTH-1:0][7:0]  mem_q;
    logic                        empty, full, push, pop;

    // Both synchronizer flops reset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // START waits half a bit to land on the start-bit centre; later states a full bit.
    assign tick = (state_q == S_START) ? (cnt_q == HALF_TC) : (cnt_q == FULL_TC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: if (tick) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (tick) begin
                cnt_d   = '0;
                shift_d = {rx_s_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = S_STOP;
            end
            S_STOP: if (tick) begin
                cnt_d   = '0;
                state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        if (state_q == S_STOP && tick) begin
            stop_ok  = rx_s_q;
            stop_bad = !rx_s_q;
        end
        rx_busy = (state_q != S_IDLE);
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && rx_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push  = stop_ok && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_q       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wptr_q[AW-1:0]] <= shift_q;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            frame_err_q <= stop_bad;
            overrun_q   <= stop_ok && full && !pop;
        end
    end

    assign rx_data       = mem_q[rptr_q[AW-1:0]];
    assign rx_valid      = !empty;
    assign frame_error   = frame_err_q;
    assign overrun_error = overrun_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame table, hand-written
// corner sequences, and random frames against a byte-stream reference model.
module tb_uart_receiver;
    localparam int CLK_FREQ   = 1_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int FIFO_DEPTH = 4;
    localparam int BD         = 10;

    logic       clk = 1'b0, rst_n = 1'b0, rx_serial = 1'b1, rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_error, overrun_error;

    uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_busy(rx_busy),
        .frame_error(frame_error), .overrun_error(overrun_error)
    );

    always #5 clk = ~clk;

    int cyc = 0, n_cmp = 0, n_fail = 0;
    int fe_cnt = 0, ov_cnt = 0, vld_cyc = 0;
    int last_pop_cyc = -1, last_fe_cyc = -1, last_ov_cyc = -1, t_start = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc++;

    // Observe one ns after the falling edge: inputs were just driven, outputs are settled.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (rx_valid) vld_cyc++;
            if (rx_valid && rx_ready) begin
                got.push_back(rx_data);
                last_pop_cyc = cyc;
            end
            if (frame_error) begin fe_cnt++; last_fe_cyc = cyc; end
            if (overrun_error) begin ov_cnt++; last_ov_cyc = cyc; end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called right after a falling edge; the start bit goes out on that edge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits    = {stop, b, 1'b0};
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_serial = bits[i];
            repeat (BD) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int n_exp);
        rx_ready = 1'b1;
        for (int k = 0; k < 300 && got.size() < n_exp; k++) @(negedge clk);
        #2;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
        int         exp_fe;
    } vec_t;
    vec_t vecs[6];

    int fe0, ov0, v0, t_bad, t5, nbad;
    logic rnd_done;
    logic [7:0] rb;
    logic rgood;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 0};
        vecs[5] = '{8'h6E, 1'b1, 1'b1, 0};

        // Reset values, while held and just after release
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", int'(rx_valid), 0);
        check("rst_data", int'(rx_data), 0);
        check("rst_busy", int'(rx_busy), 0);
        check("rst_fe", int'(frame_error), 0);
        check("rst_ov", int'(overrun_error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_valid", int'(rx_valid), 0);
        check("post_rst_busy", int'(rx_busy), 0);
        @(negedge clk);

        // Table of single frames with consumer always ready
        rx_ready = 1'b1;
        foreach (vecs[i]) begin
            got.delete();
            fe0 = fe_cnt;
            v0  = vld_cyc;
            send_frame(vecs[i].data, vecs[i].stop);
            idle(20);
            check("vec_count", got.size(), vecs[i].exp_push ? 1 : 0);
            if (vecs[i].exp_push) begin
                check("vec_data", got.size() > 0 ? int'(got[0]) : -1, int'(vecs[i].data));
                check("vec_pop_cycle", last_pop_cyc - t_start, 99);
                check("vec_valid_cycles", vld_cyc - v0, 1);
            end else begin
                check("vec_fe_cycle", last_fe_cyc - t_start, 99);
            end
            check("vec_fe_pulses", fe_cnt - fe0, vecs[i].exp_fe);
            check("vec_busy_after", int'(rx_busy), 0);
        end

        // Short low glitch on an idle line is rejected at the start check
        got.delete();
        fe0 = fe_cnt;
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        #1;
        check("glitch_busy_high", int'(rx_busy), 1);
        idle(15);
        #1;
        check("glitch_busy_low", int'(rx_busy), 0);
        check("glitch_no_byte", got.size(), 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        @(negedge clk);

        // Bad stop, line held low (break), then a good frame
        got.delete();
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        t_bad = t_start;
        repeat (30) @(negedge clk);
        #1;
        check("break_busy_wait", int'(rx_busy), 1);
        idle(20);
        send_frame(8'h81, 1'b1);
        idle(20);
        check("break_fe_pulses", fe_cnt - fe0, 1);
        check("break_fe_cycle", last_fe_cyc - t_bad, 99);
        check("break_count", got.size(), 1);
        check("break_data", got.size() > 0 ? int'(got[0]) : -1, 8'h81);

        // Overrun: five back-to-back frames into a four-entry FIFO
        rx_ready = 1'b0;
        got.delete();
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        t5 = t_start;
        idle(5);
        #1;
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_cycle", last_ov_cyc - t5, 99);
        check("ovr_head_valid", int'(rx_valid), 1);
        check("ovr_head_data", int'(rx_data), 8'h01);
        @(negedge clk);
        drain(4);
        idle(10);
        check("ovr_drain_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("ovr_drain_data", int'(got[i]), i + 1);
        rx_ready = 1'b0;

        // Full FIFO with a pop on the same edge as the fifth push
        got.delete();
        ov0 = ov_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        fork
            send_frame(8'h05, 1'b1);
            begin
                repeat (98) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        t5 = t_start;
        idle(5);
        check("fullpop_no_ovr", ov_cnt - ov0, 0);
        check("fullpop_pop_cycle", last_pop_cyc - t5, 98);
        drain(5);
        idle(10);
        check("fullpop_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("fullpop_data", int'(got[i]), i + 1);
        rx_ready = 1'b0;

        // Asynchronous reset in the middle of a frame with bytes queued
        got.delete();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(5);
        #1;
        check("mid_rst_queued", int'(rx_valid), 1);
        @(negedge clk);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (40) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("mid_rst_valid", int'(rx_valid), 0);
                check("mid_rst_busy", int'(rx_busy), 0);
                check("mid_rst_data", int'(rx_data), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idle(20);
        #1;
        check("mid_rst_no_byte", int'(rx_valid), 0);
        @(negedge clk);
        rx_ready = 1'b1;
        send_frame(8'h55, 1'b1);
        idle(20);
        check("after_rst_count", got.size(), 1);
        check("after_rst_data", got.size() > 0 ? int'(got[0]) : -1, 8'h55);

        // Random frames, random gaps, random consumer; model is the ordered good-byte stream
        got.delete();
        exp_q.delete();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        nbad = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    rb    = 8'($urandom_range(0, 255));
                    rgood = ($urandom_range(0, 7) != 0);
                    send_frame(rb, rgood);
                    if (rgood) exp_q.push_back(rb);
                    else begin
                        nbad++;
                        rx_serial = 1'b0;
                        repeat ($urandom_range(0, 20)) @(negedge clk);
                        idle(2);
                    end
                    idle($urandom_range(0, 12));
                end
                idle(30);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rx_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
            end
        join
        drain(exp_q.size());
        check("rnd_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check("rnd_data", int'(got[i]), int'(exp_q[i]));
        check("rnd_fe_pulses", fe_cnt - fe0, nbad);
        check("rnd_no_ovr", ov_cnt - ov0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
